sram_port_arbiter: RTL and testbench

- Shares the single external SRAM window (the sram_a/sram_d/sram_cs/sram_oe/sram_we/sram_wait bus of the AVR SoC) between two requesters.
- Requester 1 is the AVR core; requester 2 is a DMA master, e.g. the GD-ROM sector buffer engine.
- Sequences each access with a programmable minimum cycle count plus memory wait extension.
- Stretches the AVR with its wait input; completes DMA transfers with a one-cycle ack.

---
 rtl/sram_port_arbiter_pkg.sv | 15 +
 rtl/sram_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the external SRAM window arbiter: FSM state
// encodings and bus owner constants.
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_AVR_ACC  = 2'd1,
    ST_AVR_DONE = 2'd2,
    ST_DMA_ACC  = 2'd3
  } arb_state_e;

  localparam logic OWNER_AVR = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/sram_port_arbiter.sv
// Arbitrates the external SRAM window between the AVR core (stalled with
// avr_wait) and a DMA master (completed with a one-cycle dma_ack).
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int ACCESS_CYCLES  = 2,
  parameter int AVR_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] avr_a,
  input  logic [DATA_W-1:0] avr_wdata,
  input  logic              avr_cs,
  input  logic              avr_oe,
  input  logic              avr_we,
  output logic [DATA_W-1:0] avr_rdata,
  output logic              avr_wait,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_a,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we,
  input  logic              mem_wait,
  output logic              owner
);

  localparam int TW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int SW = (AVR_STREAK_MAX > 0) ? $clog2(AVR_STREAK_MAX + 1) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(ACCESS_CYCLES - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(AVR_STREAK_MAX);

  arb_state_e        state, state_n;
  logic [TW-1:0]     timer, timer_n;
  logic [SW-1:0]     streak, streak_n;
  logic [ADDR_W-1:0] mem_a_n;
  logic [DATA_W-1:0] mem_wdata_n, avr_rdata_n, dma_rdata_n;
  logic              mem_cs_n, mem_oe_n, mem_we_n, dma_ack_n, owner_n;
  logic              avr_req, dma_live, grant_dma, grant_avr;

  // Handshakes: the AVR holds a/wdata/strobes while avr_wait is high and
  // samples avr_rdata in the cycle avr_wait falls; the DMA holds its request
  // until dma_ack, and a request still high in the ack cycle is not regranted.
  assign avr_req   = avr_cs & (avr_oe | avr_we);
  assign avr_wait  = avr_req & (state != ST_AVR_DONE);
  assign dma_live  = dma_req & ~dma_ack;
  assign grant_dma = (state == ST_IDLE) & dma_live & (~avr_req | (streak == STREAK_MAX));
  assign grant_avr = (state == ST_IDLE) & ~grant_dma & avr_req;

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    streak_n    = streak;
    mem_a_n     = mem_a;
    mem_wdata_n = mem_wdata;
    mem_cs_n    = mem_cs;
    mem_oe_n    = mem_oe;
    mem_we_n    = mem_we;
    avr_rdata_n = avr_rdata;
    dma_rdata_n = dma_rdata;
    dma_ack_n   = 1'b0;
    owner_n     = owner;
    case (state)
      ST_IDLE: begin
        if (grant_dma) begin
          state_n     = ST_DMA_ACC;
          owner_n     = OWNER_DMA;
          mem_cs_n    = 1'b1;
          mem_we_n    = dma_we;
          mem_oe_n    = ~dma_we;
          mem_a_n     = dma_a;
          mem_wdata_n = dma_we ? dma_wdata : '0;
          timer_n     = TIMER_LOAD;
          streak_n    = '0;
        end else if (grant_avr) begin
          // Both strobes high resolves to a write.
          state_n     = ST_AVR_ACC;
          owner_n     = OWNER_AVR;
          mem_cs_n    = 1'b1;
          mem_we_n    = avr_we;
          mem_oe_n    = ~avr_we;
          mem_a_n     = avr_a;
          mem_wdata_n = avr_we ? avr_wdata : '0;
          timer_n     = TIMER_LOAD;
          if (dma_req && (streak != STREAK_MAX)) streak_n = streak + 1'b1;
        end
      end
      ST_AVR_ACC, ST_DMA_ACC: begin
        // mem_wait only stretches the access once the minimum time has run out.
        if (timer != '0) begin
          timer_n = timer - 1'b1;
        end else if (!mem_wait) begin
          mem_cs_n    = 1'b0;
          mem_oe_n    = 1'b0;
          mem_we_n    = 1'b0;
          mem_a_n     = '0;
          mem_wdata_n = '0;
          if (state == ST_AVR_ACC) begin
            if (mem_oe) avr_rdata_n = mem_rdata;
            state_n = ST_AVR_DONE;
          end else begin
            if (mem_oe) dma_rdata_n = mem_rdata;
            dma_ack_n = 1'b1;
            owner_n   = OWNER_AVR;
            state_n   = ST_IDLE;
          end
        end
      end
      ST_AVR_DONE: state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
    if (!dma_req) streak_n = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      streak    <= '0;
      mem_a     <= '0;
      mem_wdata <= '0;
      mem_cs    <= 1'b0;
      mem_oe    <= 1'b0;
      mem_we    <= 1'b0;
      avr_rdata <= '0;
      dma_rdata <= '0;
      dma_ack   <= 1'b0;
      owner     <= OWNER_AVR;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      streak    <= streak_n;
      mem_a     <= mem_a_n;
      mem_wdata <= mem_wdata_n;
      mem_cs    <= mem_cs_n;
      mem_oe    <= mem_oe_n;
      mem_we    <= mem_we_n;
      avr_rdata <= avr_rdata_n;
      dma_rdata <= dma_rdata_n;
      dma_ack   <= dma_ack_n;
      owner     <= owner_n;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM model with programmable wait extension,
// AVR/DMA driver tasks, a reference memory and directed plus random traffic.
module tb_sram_port_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int AC   = 2;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] avr_a = '0;
  logic [DW-1:0] avr_wdata = '0;
  logic          avr_cs = 1'b0, avr_oe = 1'b0, avr_we = 1'b0;
  logic [DW-1:0] avr_rdata;
  logic          avr_wait;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_a = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_cs, mem_oe, mem_we;
  logic          mem_wait = 1'b0;
  logic          owner;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC), .AVR_STREAK_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .avr_a(avr_a), .avr_wdata(avr_wdata), .avr_cs(avr_cs), .avr_oe(avr_oe),
    .avr_we(avr_we), .avr_rdata(avr_rdata), .avr_wait(avr_wait),
    .dma_req(dma_req), .dma_we(dma_we), .dma_a(dma_a), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_a(mem_a), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we), .mem_wait(mem_wait),
    .owner(owner)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memories: sram is what the modelled chip holds, ref_mem what the
  // requesters expect it to hold.
  logic [DW-1:0] sram    [int];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] exp_q   [$];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3c;
  endfunction
  function automatic logic [DW-1:0] sram_rd(input logic [AW-1:0] a);
    if (sram.exists(int'(a))) return sram[int'(a)];
    return init_val(a);
  endfunction
  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  // SRAM model and bus monitor, evaluated on the falling edge.
  int      cs_count = 0, extra_cur = 0, wait_fixed = 0, last_cs_len = 0, ack_count = 0;
  int      extra_q[$];
  logic    grant_log[$];
  logic [AW-1:0] acc_a = '0;
  logic [DW-1:0] acc_wd = '0;
  logic    acc_owner = 1'b0, acc_we = 1'b0, ack_prev = 1'b0, owner_by_addr = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      cs_count = 0;
      mem_wait = 1'b0;
      mem_rdata = '0;
    end else if (mem_cs) begin
      if (cs_count == 0) begin
        if (extra_q.size() > 0) extra_cur = extra_q.pop_front();
        else if (wait_fixed >= 0) extra_cur = wait_fixed;
        else extra_cur = $urandom_range(0, 3);
        acc_a = mem_a; acc_wd = mem_wdata; acc_owner = owner; acc_we = mem_we;
        grant_log.push_back(owner);
        chk("mem_dir_onehot", 32'(mem_oe ^ mem_we), 1);
        if (!mem_we) chk("rd_wdata_zero", 32'(mem_wdata), 0);
        if (owner_by_addr) chk("owner_vs_addr", 32'(owner), 32'(mem_a[15]));
      end else begin
        chk("mem_a_stable", 32'(mem_a), 32'(acc_a));
        chk("mem_wdata_stable", 32'(mem_wdata), 32'(acc_wd));
        chk("owner_stable", 32'(owner), 32'(acc_owner));
        chk("dir_stable", 32'(mem_we), 32'(acc_we));
      end
      cs_count++;
      mem_wait = (cs_count < AC + extra_cur);
      if (!mem_wait) begin
        if (mem_we) sram[int'(mem_a)] = mem_wdata;
        mem_rdata = mem_oe ? sram_rd(mem_a) : 8'($urandom);
      end else begin
        mem_rdata = 8'($urandom);
      end
    end else begin
      if (cs_count > 0) begin
        chk("cs_len", cs_count, AC + extra_cur);
        last_cs_len = cs_count;
      end
      cs_count  = 0;
      mem_wait  = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
    end
    if (dma_ack) begin
      ack_count++;
      chk("ack_single_cycle", 32'(ack_prev), 0);
    end
    ack_prev = dma_ack;
  end

  function automatic logic [31:0] pack_log();
    logic [31:0] v = '0;
    for (int i = 0; i < grant_log.size() && i < 32; i++) v[i] = grant_log[i];
    return v;
  endfunction

  task automatic avr_op(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic both, output int waits);
    logic [DW-1:0] exp;
    exp = '0;
    @(posedge clk) #1;
    avr_a = a; avr_wdata = d; avr_cs = 1'b1; avr_we = wr; avr_oe = ~wr | both;
    if (wr) ref_mem[int'(a)] = d;
    else exp = ref_rd(a);
    waits = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (avr_wait) waits++;
      else break;
    end
    chk("avr_wait_released", 32'(avr_wait), 0);
    if (!wr) chk("avr_rdata", 32'(avr_rdata), 32'(exp));
  endtask

  task automatic avr_release();
    @(posedge clk) #1;
    avr_cs = 1'b0; avr_oe = 1'b0; avr_we = 1'b0;
  endtask

  task automatic dma_op(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int lat);
    @(posedge clk) #1;
    dma_req = 1'b1; dma_we = wr; dma_a = a; dma_wdata = d;
    if (wr) ref_mem[int'(a)] = d;
    else exp_q.push_back(ref_rd(a));
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      lat++;
      if (dma_ack) break;
    end
    chk("dma_ack_seen", 32'(dma_ack), 1);
    if (!wr && exp_q.size() > 0) chk("dma_rdata", 32'(dma_rdata), 32'(exp_q.pop_front()));
  endtask

  task automatic dma_release();
    @(posedge clk) #1;
    dma_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, lat, a0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_cs", 32'(mem_cs), 0);
    chk("rst_mem_oe", 32'(mem_oe), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_a", 32'(mem_a), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_avr_rdata", 32'(avr_rdata), 0);
    chk("rst_dma_rdata", 32'(dma_rdata), 0);
    chk("rst_dma_ack", 32'(dma_ack), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_avr_wait", 32'(avr_wait), 0);
    @(posedge clk) #1 rst = 1'b0;

    // AVR read from an idle bus.
    wait_fixed = 0;
    sram[int'(16'hE010)] = 8'h5A;
    ref_mem[int'(16'hE010)] = 8'h5A;
    avr_op(1'b0, 16'hE010, 8'h00, 1'b0, w);
    chk("t1_avr_wait_cycles", w, AC + 1);
    chk("t1_avr_rdata", 32'(avr_rdata), 32'h5A);
    avr_release();
    chk("t1_cs_len", last_cs_len, AC);
    repeat (2) @(posedge clk);

    // DMA write stretched by mem_wait for three cycles.
    extra_q.push_back(3);
    a0 = ack_count;
    dma_op(1'b1, 16'hE123, 8'hC3, lat);
    dma_release();
    chk("t2_dma_lat", lat, AC + 3 + 2);
    chk("t2_cs_len", last_cs_len, AC + 3);
    chk("t2_mem_a", 32'(acc_a), 32'hE123);
    chk("t2_mem_wdata", 32'(acc_wd), 32'hC3);
    chk("t2_owner", 32'(acc_owner), 1);
    chk("t2_mem_we", 32'(acc_we), 1);
    chk("t2_sram_written", 32'(sram_rd(16'hE123)), 32'hC3);
    repeat (3) @(negedge clk);
    chk("t2_ack_count", ack_count - a0, 1);
    chk("t2_owner_after", 32'(owner), 0);

    // Simultaneous requests from idle with a clear streak: AVR goes first.
    grant_log.delete();
    fork
      begin avr_op(1'b0, 16'hE010, 8'h00, 1'b0, w); avr_release(); end
      begin dma_op(1'b0, 16'hE200, 8'h00, lat); dma_release(); end
    join
    chk("t3_avr_wait_cycles", w, AC + 1);
    chk("t3_dma_lat", lat, 2 * AC + 4);
    chk("t3_grant_count", grant_log.size(), 2);
    chk("t3_grant_order", pack_log(), 32'h2);
    repeat (2) @(posedge clk);

    // AVR streak limit with continuous AVR traffic and two queued DMA requests.
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) avr_op(1'b0, 16'h1000 + 16'(i), 8'h00, 1'b0, w);
        avr_release();
      end
      begin
        dma_op(1'b0, 16'h9000, 8'h00, lat);
        dma_op(1'b0, 16'h9001, 8'h00, lat);
        dma_release();
      end
    join
    chk("t4_grant_count", grant_log.size(), 12);
    chk("t4_grant_order", pack_log(), 32'h0210);
    repeat (2) @(posedge clk);
    grant_log.delete();
    fork
      begin avr_op(1'b0, 16'h1100, 8'h00, 1'b0, w); avr_release(); end
      begin dma_op(1'b0, 16'h9100, 8'h00, lat); dma_release(); end
    join
    chk("t4_streak_cleared_order", pack_log(), 32'h2);
    repeat (2) @(posedge clk);

    // Reset in the second cycle of a DMA read.
    extra_q.push_back(3);
    @(posedge clk) #1;
    dma_req = 1'b1; dma_we = 1'b0; dma_a = 16'hE300;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_cs) break;
    end
    chk("t5_dma_started", 32'(mem_cs), 1);
    a0 = ack_count;
    @(posedge clk) #1 rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    chk("t5_mem_cs", 32'(mem_cs), 0);
    chk("t5_mem_oe", 32'(mem_oe), 0);
    chk("t5_owner", 32'(owner), 0);
    repeat (6) @(negedge clk);
    chk("t5_no_ack", ack_count - a0, 0);
    avr_op(1'b0, 16'hE010, 8'h00, 1'b0, w);
    chk("t5_avr_wait_cycles", w, AC + 1);
    chk("t5_avr_rdata", 32'(avr_rdata), 32'h5A);
    avr_release();
    repeat (2) @(posedge clk);

    // AVR request arriving in the third cycle of a stretched DMA read.
    sram[int'(16'hE020)] = 8'h77;
    ref_mem[int'(16'hE020)] = 8'h77;
    extra_q.push_back(2);
    extra_q.push_back(0);
    fork
      begin
        dma_op(1'b0, 16'hE400, 8'h00, lat);
        chk("t6_avr_rdata_kept", 32'(avr_rdata), 32'h5A);
        dma_release();
      end
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (mem_cs) break;
        end
        @(negedge clk);
        avr_op(1'b0, 16'hE020, 8'h00, 1'b0, w);
        chk("t6_avr_wait_cycles", w, (AC + 2 - 3 + 1) + 1 + AC);
        chk("t6_avr_rdata", 32'(avr_rdata), 32'h77);
        avr_release();
      end
    join
    repeat (2) @(posedge clk);

    // Random concurrent traffic in disjoint address windows.
    wait_fixed = -1;
    owner_by_addr = 1'b1;
    fork
      begin
        logic wr, both;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int wa;
        for (int i = 0; i < 30; i++) begin
          wr = 1'($urandom_range(0, 1));
          both = 1'($urandom_range(0, 1));
          a = 16'($urandom_range(16'h0100, 16'h010F));
          d = 8'($urandom);
          avr_op(wr, a, d, both, wa);
          chk("rnd_avr_wait_bound", 32'(wa <= 2 * AC + 9), 1);
          if ($urandom_range(0, 2) == 0) begin
            avr_release();
            repeat ($urandom_range(0, 4)) @(posedge clk);
          end
        end
        avr_release();
      end
      begin
        logic wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int la;
        for (int i = 0; i < 15; i++) begin
          wr = 1'($urandom_range(0, 1));
          a = 16'($urandom_range(16'h8100, 16'h810F));
          d = 8'($urandom);
          dma_op(wr, a, d, la);
          chk("rnd_dma_lat_bound", 32'(la <= (SMAX + 2) * (2 * AC + 8)), 1);
          if ($urandom_range(0, 1) == 0) begin
            dma_release();
            repeat ($urandom_range(0, 6)) @(posedge clk);
          end
        end
        dma_release();
      end
    join
    owner_by_addr = 1'b0;
    repeat (4) @(posedge clk);
    chk("end_exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
